// File: rtl/or_multi_pkg.sv
// -----------------------------------------------------------------------------
// or_multi_pkg
// Shared types and defaults for the or_multi_sticky aggregate event flag.
//   state_t        : FSM encoding (IDLE, HOLD, WAIT_CLR)
//   DEF_*          : default parameter values
//   lowest_set_idx : index of the lowest set bit of a vector up to MAX_N wide
// -----------------------------------------------------------------------------
package or_multi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  localparam int DEF_N        = 5;
  localparam int DEF_MIN_HOLD = 3;
  localparam int DEF_CNT_W    = 8;
  localparam int MAX_N        = 32;
  localparam int MAX_ID_W     = 5;

  // Callers zero-extend narrower vectors to MAX_N; returns 0 for an all-zero vector.
  function automatic logic [MAX_ID_W-1:0] lowest_set_idx(input logic [MAX_N-1:0] v);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (v[i]) idx = MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/or_multi_sticky_if.sv
// -----------------------------------------------------------------------------
// or_multi_sticky_if
// Event/status bundle between event sources and or_multi_sticky.
//   in_vec, mask, clr_vec : driven by the master (event side)
//   w, status, first_id, event_cnt : driven by the slave (or_multi_sticky)
// -----------------------------------------------------------------------------
interface or_multi_sticky_if #(
  parameter int N     = 5,
  parameter int CNT_W = 8,
  parameter int ID_W  = 3
);
  logic [N-1:0]     in_vec;
  logic [N-1:0]     mask;
  logic [N-1:0]     clr_vec;
  logic             w;
  logic [N-1:0]     status;
  logic [ID_W-1:0]  first_id;
  logic [CNT_W-1:0] event_cnt;

  modport master (
    output in_vec, mask, clr_vec,
    input  w, status, first_id, event_cnt
  );

  modport slave (
    input  in_vec, mask, clr_vec,
    output w, status, first_id, event_cnt
  );
endinterface

// File: rtl/or_multi_prio_enc.sv
// -----------------------------------------------------------------------------
// or_multi_prio_enc
// N-bit lowest-index-wins priority encoder.
//   i_vec   : request vector
//   o_idx   : index of the lowest set bit (0 when none set)
//   o_valid : at least one bit of i_vec set
// -----------------------------------------------------------------------------
module or_multi_prio_enc
  import or_multi_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_vec,
  output logic [ID_W-1:0] o_idx,
  output logic            o_valid
);

  logic [MAX_N-1:0]    w_vec_ext;
  logic [MAX_ID_W-1:0] w_idx_full;

  assign w_vec_ext  = MAX_N'(i_vec);
  assign w_idx_full = lowest_set_idx(w_vec_ext);
  assign o_idx      = ID_W'(w_idx_full);
  assign o_valid    = |i_vec;

endmodule

// File: rtl/or_multi_sticky.sv
// -----------------------------------------------------------------------------
// or_multi_sticky
// Masked OR of N event channels into a registered flag w, with per-channel
// sticky status, a minimum w-high time, first-hit channel capture and a
// saturating count of IDLE->HOLD transitions.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : or_multi_sticky_if.slave (in_vec, mask, clr_vec -> w, status,
//              first_id, event_cnt)
// Build option: OR_MULTI_EDGE_EN makes inputs rising-edge sensitive (adds an
// in_vec history register); undefined leaves them level sensitive.
//
// state    | meaning
// IDLE     | w=0, waiting for any unmasked hit
// HOLD     | w=1, minimum-hold countdown running
// WAIT_CLR | w=1, hold done, waiting for all sticky bits to be cleared
// -----------------------------------------------------------------------------
module or_multi_sticky
  import or_multi_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ID_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  or_multi_sticky_if.slave bus
);

  localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  logic [N-1:0]      w_hit;
  logic [N-1:0]      w_status_next;
  logic [N-1:0]      r_status;
  state_t            r_state, w_state_next;
  logic [HOLD_W-1:0] r_cnt, w_cnt_next;
  logic              r_w, w_w_next;
  logic [ID_W-1:0]   r_first_id, w_first_id_next, w_enc_idx;
  logic              w_enc_valid;
  logic [CNT_W-1:0]  r_event_cnt, w_event_cnt_next;

`ifdef OR_MULTI_EDGE_EN
  logic [N-1:0] r_in_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_q <= '0;
    else     r_in_q <= bus.in_vec;
  end

  assign w_hit = bus.in_vec & ~r_in_q & ~bus.mask;
`else
  assign w_hit = bus.in_vec & ~bus.mask;
`endif

  // Set wins over clear on the same bit; mask only gates new hits.
  assign w_status_next = (r_status & ~bus.clr_vec) | w_hit;

  or_multi_prio_enc #(
    .N    (N),
    .ID_W (ID_W)
  ) u_prio_enc (
    .i_vec   (w_hit),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_w_next         = r_w;
    w_first_id_next  = r_first_id;
    w_event_cnt_next = r_event_cnt;
    case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_next    = HOLD;
          w_w_next        = 1'b1;
          w_cnt_next      = HOLD_W'(MIN_HOLD - 1);
          w_first_id_next = w_enc_idx;
          if (r_event_cnt != '1) w_event_cnt_next = r_event_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - HOLD_W'(1);
        end else if (|w_status_next) begin
          w_state_next = WAIT_CLR;
        end else begin
          w_state_next = IDLE;
          w_w_next     = 1'b0;
        end
      end
      WAIT_CLR: begin
        if (w_status_next == '0) begin
          w_state_next = IDLE;
          w_w_next     = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_w_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_w         <= 1'b0;
      r_status    <= '0;
      r_first_id  <= '0;
      r_event_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_w         <= w_w_next;
      r_status    <= w_status_next;
      r_first_id  <= w_first_id_next;
      r_event_cnt <= w_event_cnt_next;
    end
  end

  assign bus.w         = r_w;
  assign bus.status    = r_status;
  assign bus.first_id  = r_first_id;
  assign bus.event_cnt = r_event_cnt;

endmodule

// File: tb/tb_or_multi_sticky.sv
module tb_or_multi_sticky;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_vec  = '0;
  logic [4:0] mask    = '0;
  logic [4:0] clr_vec = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Main instance: N=5, MIN_HOLD=3, CNT_W=8
  or_multi_sticky_if #(.N(5), .CNT_W(8), .ID_W(3)) bus0 ();
  // Saturation instance: CNT_W=2, same stimulus
  or_multi_sticky_if #(.N(5), .CNT_W(2), .ID_W(3)) bus1 ();

  assign bus0.in_vec  = in_vec;
  assign bus0.mask    = mask;
  assign bus0.clr_vec = clr_vec;
  assign bus1.in_vec  = in_vec;
  assign bus1.mask    = mask;
  assign bus1.clr_vec = clr_vec;

  or_multi_sticky #(.N(5), .MIN_HOLD(3), .CNT_W(8), .ID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  or_multi_sticky #(.N(5), .MIN_HOLD(3), .CNT_W(2), .ID_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [4:0] in_v;
    logic [4:0] msk;
    logic [4:0] clr;
    logic       ew;
    logic [4:0] est;
    logic [2:0] efid;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in, mask, clr -> w, status, first_id, event_cnt
    tbl.push_back('{5'b00010, 5'b00000, 5'b00000, 1'b1, 5'b00010, 3'd1, 8'd1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00010, 1'b1, 5'b00000, 3'd1, 8'd1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd1, 8'd1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd1, 8'd1});
    tbl.push_back('{5'b10001, 5'b00000, 5'b00000, 1'b1, 5'b10001, 3'd0, 8'd2});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b10001, 3'd0, 8'd2});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00001, 1'b1, 5'b10000, 3'd0, 8'd2});
    tbl.push_back('{5'b00000, 5'b00000, 5'b10000, 1'b0, 5'b00000, 3'd0, 8'd2});
    tbl.push_back('{5'b00100, 5'b00100, 5'b00000, 1'b0, 5'b00000, 3'd0, 8'd2});
    tbl.push_back('{5'b00100, 5'b00100, 5'b00000, 1'b0, 5'b00000, 3'd0, 8'd2});
    tbl.push_back('{5'b01100, 5'b00100, 5'b01000, 1'b1, 5'b01000, 3'd3, 8'd3});
    tbl.push_back('{5'b00000, 5'b01000, 5'b00000, 1'b1, 5'b01000, 3'd3, 8'd3});
    tbl.push_back('{5'b00000, 5'b01000, 5'b00000, 1'b1, 5'b01000, 3'd3, 8'd3});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b01000, 3'd3, 8'd3});
    tbl.push_back('{5'b00000, 5'b00000, 5'b01000, 1'b0, 5'b00000, 3'd3, 8'd3});
    tbl.push_back('{5'b00100, 5'b00000, 5'b00000, 1'b1, 5'b00100, 3'd2, 8'd4});
    tbl.push_back('{5'b00001, 5'b00000, 5'b00000, 1'b1, 5'b00101, 3'd2, 8'd4});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00101, 1'b1, 5'b00000, 3'd2, 8'd4});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd2, 8'd4});

    // Reset values
    tick();
    check("rst_w",      32'(bus0.w),         32'd0);
    check("rst_status", 32'(bus0.status),    32'd0);
    check("rst_fid",    32'(bus0.first_id),  32'd0);
    check("rst_cnt",    32'(bus0.event_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_w", 32'(bus0.w), 32'd0);

    // Directed vector table
    foreach (tbl[i]) begin
      in_vec  = tbl[i].in_v;
      mask    = tbl[i].msk;
      clr_vec = tbl[i].clr;
      tick();
      check($sformatf("v%0d_w", i),      32'(bus0.w),         32'(tbl[i].ew));
      check($sformatf("v%0d_status", i), 32'(bus0.status),    32'(tbl[i].est));
      check($sformatf("v%0d_fid", i),    32'(bus0.first_id),  32'(tbl[i].efid));
      check($sformatf("v%0d_cnt", i),    32'(bus0.event_cnt), 32'(tbl[i].ecnt));
    end
    in_vec = '0; mask = '0; clr_vec = '0;

    // Asynchronous reset during HOLD
    in_vec = 5'b00100;
    tick();
    check("mid_hit_w", 32'(bus0.w), 32'd1);
    in_vec = 5'b00000;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_w",      32'(bus0.w),         32'd0);
    check("arst_status", 32'(bus0.status),    32'd0);
    check("arst_cnt",    32'(bus0.event_cnt), 32'd0);
    check("arst_fid",    32'(bus0.first_id),  32'd0);
    in_vec = 5'b00100;
    tick();
    check("rst_held_w",      32'(bus0.w),      32'd0);
    check("rst_held_status", 32'(bus0.status), 32'd0);
    in_vec = 5'b00000;
    rst = 1'b0;
    tick();
    check("post_rst_w",   32'(bus0.w),         32'd0);
    check("post_rst_cnt", 32'(bus0.event_cnt), 32'd0);

    // Counter saturation on channel 4
    for (int k = 0; k < 5; k++) begin
      in_vec = 5'b10000;
      tick();
      check($sformatf("sat%0d_cnt2", k), 32'(bus1.event_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
      check($sformatf("sat%0d_cnt8", k), 32'(bus0.event_cnt), 32'(k + 1));
      check($sformatf("sat%0d_fid", k),  32'(bus0.first_id),  32'd4);
      in_vec  = 5'b00000;
      clr_vec = 5'b10000;
      tick();
      clr_vec = 5'b00000;
      tick();
      tick();
      check($sformatf("sat%0d_wlow", k), 32'(bus0.w), 32'd0);
    end

    // Channel 0 held high for 20 cycles with a clear pulse at cycle 5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      in_vec  = 5'b00001;
      clr_vec = (c == 5) ? 5'b00001 : 5'b00000;
      tick();
      if (c == 1) begin
        check("hold_c1_w",   32'(bus0.w),         32'd1);
        check("hold_c1_cnt", 32'(bus0.event_cnt), 32'd1);
      end
      if (c == 4) check("hold_c4_w", 32'(bus0.w), 32'd1);
`ifdef OR_MULTI_EDGE_EN
      if (c == 5) begin
        check("edge_c5_w",      32'(bus0.w),      32'd0);
        check("edge_c5_status", 32'(bus0.status), 32'd0);
      end
      if (c == 20) begin
        check("edge_c20_w",   32'(bus0.w),         32'd0);
        check("edge_c20_cnt", 32'(bus0.event_cnt), 32'd1);
      end
`else
      if (c == 5) begin
        check("lvl_c5_w",      32'(bus0.w),      32'd1);
        check("lvl_c5_status", 32'(bus0.status), 32'd1);
      end
      if (c == 20) begin
        check("lvl_c20_w",   32'(bus0.w),         32'd1);
        check("lvl_c20_cnt", 32'(bus0.event_cnt), 32'd1);
      end
`endif
    end
    in_vec  = 5'b00000;
    clr_vec = 5'b00001;
    tick();
    clr_vec = 5'b00000;
    check("hold_end_w",      32'(bus0.w),         32'd0);
    check("hold_end_status", 32'(bus0.status),    32'd0);
    check("hold_end_cnt",    32'(bus0.event_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or_multi_sticky.md
Name: or_multi_sticky

Overview:
Parametrised successor of the multi-input OR. N independent event inputs are masked and OR-reduced into a registered aggregate flag `w`. Each channel has a sticky status bit. `w` has a guaranteed minimum hold time and stays high until all sticky bits are cleared. The block also records the first-hit channel and keeps a saturating event count. It sits between peripheral event sources and a single interrupt or monitor line, and is a target for the team's SVA property examples.

Parameters:
N, 5, number of input channels (1..32).
MIN_HOLD, 3, minimum cycles `w` stays high once asserted (>=1).
CNT_W, 8, width of the saturating aggregate-event counter.
ID_W, $clog2(N) (min 1), width of the first-hit channel index.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
in_vec  in  N  event inputs, level-sensitive (edge-sensitive under the optional feature).
mask  in  N  1 = channel ignored; has no effect on bits already sticky.
clr_vec  in  N  1 = clear that channel's sticky bit this cycle.
w  out  1  registered aggregate flag.
status  out  N  sticky bits.
first_id  out  ID_W  lowest-index channel that caused the latest IDLE->HOLD transition.
event_cnt  out  CNT_W  number of IDLE->HOLD transitions, saturating.

Behaviour:
- Reset (async, `rst`=1):
  - w=0, status=0, first_id=0, event_cnt=0, state=IDLE, hold counter=0.
  - Reset asserted mid-operation aborts immediately to these values; no event in that cycle is retained.
- hit = in_vec & ~mask (combinational).
- Sticky update each posedge: status <= (status & ~clr_vec) | hit.
  - Set and clear on the same bit in the same cycle: set wins.
  - status_next denotes this new value.
- Latency: an input high at posedge t is visible on status and w after edge t, i.e. 1 cycle.
- FSM states IDLE, HOLD, WAIT_CLR:
  - IDLE (w=0): if |hit, go to HOLD, w<=1, cnt<=MIN_HOLD-1, first_id<=lowest set index of hit, event_cnt+1 (saturating at all-ones). Otherwise stay.
  - HOLD (w=1): if cnt!=0, decrement. If cnt==0: go to WAIT_CLR when |status_next, else go to IDLE with w<=0.
  - WAIT_CLR (w=1): when status_next==0, go to IDLE with w<=0. Otherwise stay.
- Total w-high time: at least MIN_HOLD cycles. MIN_HOLD=1 gives a one-cycle HOLD.
- New hits during HOLD/WAIT_CLR:
  - Only set sticky bits.
  - Do not change first_id, event_cnt or restart cnt.
- Clears during HOLD do not shorten the hold.
- A hit arriving the same cycle the FSM returns to IDLE is kept in status. It starts a new HOLD on the next cycle if still present, otherwise w goes high again via WAIT_CLR logic only if re-hit. Precisely: the IDLE decision uses hit only.
- Masking a channel whose sticky bit is set leaves it set until cleared.
- event_cnt at all-ones stays all-ones.
- first_id priority: lowest index wins.

Optional Feature:
OR_MULTI_EDGE_EN
- Defined:
  - A registered copy in_q of in_vec is added (reset 0).
  - hit = in_vec & ~in_q & ~mask, so only rising edges register.
  - A held-high input produces one hit.
  - Latency is unchanged: the edge is seen at the first posedge where in_vec=1 and in_q=0.
- Undefined:
  - Level-sensitive as described; no in_q register.

Decomposition:
- Package or_multi_pkg:
  - state enum typedef (IDLE, HOLD, WAIT_CLR, 2-bit).
  - function lowest_set_idx (generic over width via parameterised class-static or max-width vector).
  - default parameter constants.
- Sub-module or_multi_prio_enc (N-bit lowest-index priority encoder with valid output), instantiated once for first_id.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: N=5, MIN_HOLD=3, in_vec=5'b00100 at edge 2, rst pulsed at edge 3.
  - Required: w=0, status=0, event_cnt=0 immediately on rst rise, with no clock needed.
- Single pulse and minimum hold:
  - Stimulus: N=5, MIN_HOLD=3; one-cycle in_vec=5'b00010, then clr_vec=5'b00010 on the next cycle.
  - Required: w high exactly 3 cycles, first_id=1, event_cnt=1, status[1] cleared after 1 cycle.
- Sticky until cleared:
  - Stimulus: in_vec=5'b10001 for one cycle, no clear for 10 cycles, then clr_vec=5'b00001, then clr_vec=5'b10000.
  - Required: first_id=0; w stays 1 until the cycle after the second clear, then 0; event_cnt=1.
- Mask and set/clear collision:
  - Stimulus: mask=5'b00100 with in_vec=5'b00100.
  - Required: w stays 0, status=0.
  - Stimulus: then in_vec[3]=1 with clr_vec[3]=1 in the same cycle.
  - Required: status[3]=1.
- Counter saturation:
  - Stimulus: CNT_W=2; 5 separate pulse/clear cycles on channel 4.
  - Required: event_cnt reads 1,2,3,3,3.
- Edge mode (OR_MULTI_EDGE_EN):
  - Stimulus: in_vec[0] held high 20 cycles, clr_vec[0] pulsed at cycle 5.
  - Required: one hit only, event_cnt=1, w falls after the clear is taken with MIN_HOLD satisfied.
